// File: rtl/ysyx_220066_if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package ysyx_220066_if_fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // One decode-bound entry: fault flag, fetch PC and instruction word.
  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses must be word aligned.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_220066_if_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is shown without a pop.
module ysyx_220066_if_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_en;
  logic             push_en;

  // Ignore pops when empty and pushes when full unless a pop frees a slot.
  always_comb begin
    pop_en  = pop && (count_q != '0);
    push_en = push && ((count_q != CW'(DEPTH)) || pop_en);
  end

  // Pointer and occupancy tracking; flush empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (push_en && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ysyx_220066_if_fetch.sv
// Instruction-fetch front end: in-order imem requests, response buffering,
// redirect squashing of stale responses and fault reporting to decode.
module ysyx_220066_if_fetch
  import ysyx_220066_if_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        block,
  input  logic        jmp,
  input  logic [63:0] jmp_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        valid_out,
  output logic [31:0] instr,
  output logic [63:0] pc_out,
  output logic        instr_error
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  fetch_state_e    state_q, state_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            fault_pend_q, fault_pend_d;

  logic [CW-1:0]   inflight;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   inflight_next;
  logic [CW:0]     occupancy;
  logic [63:0]     pcq_head;
  logic            req_fire;
  logic            resp_drop;
  logic            ibuf_push;
  logic            ibuf_pop;
  fetch_entry_t    ibuf_wdata;
  fetch_entry_t    ibuf_head;

  // Request channel: credits cover both in-flight requests and buffered words.
  always_comb begin
    occupancy      = (CW+1)'(inflight) + (CW+1)'(buf_count);
    imem_req_valid = rst && (state_q == ST_RUN) && !jmp && (occupancy < (CW+1)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    inflight_next  = inflight + CW'(req_fire) - CW'(imem_resp_valid);
    resp_drop      = imem_resp_valid && (drop_cnt_q != '0);
  end

  // PC of every outstanding request, popped as responses return in order.
  ysyx_220066_if_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (imem_resp_valid),
    .flush     (1'b0),
    .head      (pcq_head),
    .count     (inflight)
  );

  // Returned instructions awaiting decode.
  ysyx_220066_if_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (ibuf_push),
    .push_data (ibuf_wdata),
    .pop       (ibuf_pop),
    .flush     (jmp),
    .head      (ibuf_head),
    .count     (buf_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      fetch_pc_q   <= RESET_PC;
      drop_cnt_q   <= '0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_cnt_q   <= drop_cnt_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  // Next-state: advance PC, retire or drop responses, handle redirects.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drop_cnt_d   = drop_cnt_q;
    fault_pend_d = 1'b0;
    ibuf_push    = 1'b0;
    ibuf_wdata   = '0;

    if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
    if (resp_drop) drop_cnt_d = drop_cnt_q - CW'(1);

    if (fault_pend_q) begin
      // Misaligned redirect target becomes a fault entry; fetch_pc holds it.
      ibuf_push        = 1'b1;
      ibuf_wdata.err   = 1'b1;
      ibuf_wdata.pc    = fetch_pc_q;
      ibuf_wdata.instr = NOP_INSTR;
      state_d          = ST_HALT;
    end else if (imem_resp_valid && !resp_drop) begin
      ibuf_push        = 1'b1;
      ibuf_wdata.err   = imem_resp_err;
      ibuf_wdata.pc    = pcq_head;
      ibuf_wdata.instr = imem_resp_err ? NOP_INSTR : imem_resp_data;
      if (imem_resp_err) state_d = ST_HALT;
    end

    if (jmp) begin
      // Every request still outstanding after this cycle returns stale data.
      ibuf_push  = 1'b0;
      drop_cnt_d = inflight_next;
      fetch_pc_d = jmp_pc;
      if (pc_misaligned(jmp_pc)) begin
        state_d      = ST_HALT;
        fault_pend_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  // Decode-facing view of the buffer head, zeroed when empty.
  always_comb begin
    valid_out   = (buf_count != '0);
    instr       = valid_out ? ibuf_head.instr : '0;
    pc_out      = valid_out ? ibuf_head.pc    : '0;
    instr_error = valid_out ? ibuf_head.err   : 1'b0;
    ibuf_pop    = valid_out && !block && !jmp;
  end

  // Credit and protocol sanity: no buffer overflow, no response without a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!ibuf_push || (buf_count < CW'(DEPTH)) || ibuf_pop);
      assert (!imem_resp_valid || (inflight != '0));
    end
  end

endmodule

// File: tb/tb_ysyx_220066_if_fetch.sv
// Directed bench for the fetch front end with a small in-order memory model.
module tb_ysyx_220066_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        block;
  logic        jmp;
  logic [63:0] jmp_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        valid_out;
  logic [31:0] instr;
  logic [63:0] pc_out;
  logic        instr_error;

  int          n_cmp = 0;
  int          n_bad = 0;

  logic        hold;
  logic [63:0] err_addr;
  logic [63:0] mem_q [$];
  logic [63:0] mem_a;
  logic [63:0] last_acc_addr;
  int          acc_cnt = 0;
  int          max_out;

  ysyx_220066_if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .block           (block),
    .jmp             (jmp),
    .jmp_pc          (jmp_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .valid_out       (valid_out),
    .instr           (instr),
    .pc_out          (pc_out),
    .instr_error     (instr_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  // Memory: accepts every request, answers in order one cycle later unless held.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= '0;
      imem_resp_err   <= 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back(imem_req_addr);
        acc_cnt++;
        last_acc_addr = imem_req_addr;
      end
      if (!hold && mem_q.size() > 0) begin
        mem_a = mem_q.pop_front();
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= exp_word(mem_a);
        imem_resp_err   <= (mem_a == err_addr);
      end else begin
        imem_resp_valid <= 1'b0;
        imem_resp_data  <= '0;
        imem_resp_err   <= 1'b0;
      end
    end
  end

  // Track the deepest outstanding request count seen by the memory.
  always @(negedge clk) begin
    if (rst && (mem_q.size() + int'(imem_resp_valid) > max_out))
      max_out = mem_q.size() + int'(imem_resp_valid);
  end

  task automatic do_reset();
    rst = 1'b0; block = 1'b0; jmp = 1'b0; jmp_pc = '0;
    hold = 1'b0; err_addr = '1; imem_req_ready = 1'b1; max_out = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_acc(input int target, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (acc_cnt >= target) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; block = 1'b0; jmp = 1'b0; jmp_pc = '0;
    hold = 1'b0; err_addr = '1; imem_req_ready = 1'b1; max_out = 0;
    @(negedge clk);
    n_cmp++;
    if (valid_out !== 1'b0 || instr !== 32'h0 || pc_out !== 64'h0 || instr_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: v=%b instr=%h pc=%h err=%b, required all zero", valid_out, instr, pc_out, instr_error);
    end
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_req_valid: got %b required 0", imem_req_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
      n_bad++;
      $display("FAIL reset_first_req: valid=%b addr=%h required 1 / 80000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_straight();
    bit got;
    logic [63:0] epc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      epc = 64'h8000_0000 + 64'(4 * i);
      wait_valid(got);
      n_cmp++;
      if (!got || pc_out !== epc || instr !== exp_word(epc) || instr_error !== 1'b0) begin
        n_bad++;
        $display("FAIL straight_%0d: got=%b pc=%h instr=%h err=%b required pc=%h instr=%h err=0", i, got, pc_out, instr, instr_error, epc, exp_word(epc));
      end
    end
    n_cmp++;
    if (max_out > 2) begin
      n_bad++;
      $display("FAIL straight_outstanding: got %0d required <= 2", max_out);
    end
  endtask

  task automatic test_stall();
    bit got;
    logic [63:0] epc;
    do_reset();
    wait_valid(got);
    block = 1'b1;
    n_cmp++;
    if (!got || pc_out !== 64'h8000_0000) begin
      n_bad++;
      $display("FAIL stall_first: got=%b pc=%h required 80000000", got, pc_out);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== 1'b1 || pc_out !== 64'h8000_0000 || instr !== 32'h25A5_0000) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: v=%b pc=%h instr=%h required 1 / 80000000 / 25a50000", i, valid_out, pc_out, instr);
      end
    end
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_req_valid: got %b required 0", imem_req_valid);
    end
    block = 1'b0;
    for (int i = 1; i < 4; i++) begin
      epc = 64'h8000_0000 + 64'(4 * i);
      wait_valid(got);
      n_cmp++;
      if (!got || pc_out !== epc || instr !== exp_word(epc)) begin
        n_bad++;
        $display("FAIL stall_resume_%0d: got=%b pc=%h instr=%h required pc=%h instr=%h", i, got, pc_out, instr, epc, exp_word(epc));
      end
    end
  endtask

  task automatic test_redirect();
    bit got;
    int base;
    do_reset();
    hold = 1'b1;
    base = acc_cnt;
    wait_acc(base + 2, got);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL redirect_setup: accepted %0d required 2", acc_cnt - base);
    end
    jmp = 1'b1; jmp_pc = 64'h8000_0100;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redirect_no_req: got %b required 0", imem_req_valid);
    end
    @(negedge clk);
    jmp = 1'b0; hold = 1'b0;
    wait_valid(got);
    n_cmp++;
    if (!got || pc_out !== 64'h8000_0100 || instr !== 32'h25A5_0100 || instr_error !== 1'b0) begin
      n_bad++;
      $display("FAIL redirect_target: got=%b pc=%h instr=%h err=%b required 80000100 / 25a50100 / 0", got, pc_out, instr, instr_error);
    end
  endtask

  task automatic test_misaligned();
    bit got;
    do_reset();
    wait_acc(acc_cnt + 1, got);
    jmp = 1'b1; jmp_pc = 64'h8000_0102;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_jmp_req: got %b required 0", imem_req_valid);
    end
    @(negedge clk);
    jmp = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_pend_req: got %b required 0", imem_req_valid);
    end
    wait_valid(got);
    n_cmp++;
    if (!got || pc_out !== 64'h8000_0102 || instr !== 32'h0 || instr_error !== 1'b1) begin
      n_bad++;
      $display("FAIL misalign_entry: got=%b pc=%h instr=%h err=%b required 80000102 / 0 / 1", got, pc_out, instr, instr_error);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== 1'b0 || imem_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL misalign_idle_%0d: v=%b req=%b required 0 / 0", i, valid_out, imem_req_valid);
      end
    end
    jmp = 1'b1; jmp_pc = 64'h8000_0200;
    @(negedge clk);
    jmp = 1'b0;
    wait_valid(got);
    n_cmp++;
    if (!got || pc_out !== 64'h8000_0200 || instr !== 32'h25A5_0200 || instr_error !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_resume: got=%b pc=%h instr=%h required 80000200 / 25a50200", got, pc_out, instr);
    end
  endtask

  task automatic test_bus_fault();
    bit got;
    logic [63:0] epc;
    do_reset();
    err_addr = 64'h8000_0008;
    for (int i = 0; i < 3; i++) begin
      epc = 64'h8000_0000 + 64'(4 * i);
      wait_valid(got);
      n_cmp++;
      if (i < 2) begin
        if (!got || pc_out !== epc || instr !== exp_word(epc) || instr_error !== 1'b0) begin
          n_bad++;
          $display("FAIL fault_pre_%0d: got=%b pc=%h instr=%h err=%b required pc=%h err=0", i, got, pc_out, instr, instr_error, epc);
        end
      end else begin
        if (!got || pc_out !== epc || instr !== 32'h0 || instr_error !== 1'b1) begin
          n_bad++;
          $display("FAIL fault_entry: got=%b pc=%h instr=%h err=%b required 80000008 / 0 / 1", got, pc_out, instr, instr_error);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fault_halt_req_%0d: got %b required 0", i, imem_req_valid);
      end
    end
    jmp = 1'b1; jmp_pc = 64'h8000_0100;
    @(negedge clk);
    jmp = 1'b0;
    wait_valid(got);
    n_cmp++;
    if (!got || pc_out !== 64'h8000_0100 || instr_error !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_redirect: got=%b pc=%h err=%b required 80000100 / 0", got, pc_out, instr_error);
    end
  endtask

  task automatic test_jmp_block();
    bit got;
    do_reset();
    block = 1'b1;
    wait_valid(got);
    jmp = 1'b1; jmp_pc = 64'h8000_0300;
    @(negedge clk);
    jmp = 1'b0;
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL jmp_block_flush: valid_out=%b required 0", valid_out);
    end
    block = 1'b0;
    wait_valid(got);
    n_cmp++;
    if (!got || pc_out !== 64'h8000_0300 || instr !== 32'h25A5_0300) begin
      n_bad++;
      $display("FAIL jmp_block_target: got=%b pc=%h instr=%h required 80000300 / 25a50300", got, pc_out, instr);
    end
  endtask

  task automatic test_async_reset();
    bit got;
    int snap;
    do_reset();
    block = 1'b1;
    wait_valid(got);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || instr !== 32'h0 || pc_out !== 64'h0 || instr_error !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_outputs: v=%b instr=%h pc=%h err=%b req=%b required all zero", valid_out, instr, pc_out, instr_error, imem_req_valid);
    end
    @(negedge clk);
    block = 1'b0;
    snap = acc_cnt;
    rst = 1'b1;
    wait_acc(snap + 1, got);
    n_cmp++;
    if (!got || last_acc_addr !== 64'h8000_0000) begin
      n_bad++;
      $display("FAIL async_reset_first_req: got=%b addr=%h required 80000000", got, last_acc_addr);
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_stall();
    test_redirect();
    test_misaligned();
    test_bus_fault();
    test_jmp_block();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
